// File: rtl/tff_stream_decoder.sv
// tff_stream_decoder
// Recovers the T bit stream from a sampled toggle flip-flop output line
// (t = q ^ q_prev) and packs it LSB-first into WIDTH-bit words, which are
// handed downstream through a one-word valid/ready output buffer.
//
// Build option: define TFF_DEC_PARITY_EN to expect one trailing even-parity
// bit per word. Words that fail the check pulse parity_err and are dropped
// without affecting data_out, data_valid or overflow. Without the macro,
// frames are WIDTH bits long and parity_err is tied low.
//
// state | meaning
// IDLE  | between frames, bit_cnt = 0, next sample is data bit 0
// SHIFT | collecting data bits 1..WIDTH-1
// PAR   | data word held in shift_reg, next sample is the parity bit
//         (exists only with TFF_DEC_PARITY_EN)
module tff_stream_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             q_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  output logic             parity_err
);

  // bit_cnt only ever holds 0..WIDTH-1: the sample that would make it WIDTH
  // completes the word and returns it to 0 in the same edge.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t             state;
  logic               q_prev;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   shift_reg;

  logic               t_bit;
  logic [WIDTH-1:0]   word_next;
  logic               last_bit;
  logic               word_done;
  logic [WIDTH-1:0]   word_val;
  logic               buf_free;
`ifdef TFF_DEC_PARITY_EN
  logic               par_ok;
  logic               par_bad;
`endif

  // Decode the current sample and work out whether a word completes on it.
  always_comb begin
    t_bit              = q_in ^ q_prev;
    word_next          = shift_reg;
    word_next[bit_cnt] = t_bit;
    last_bit           = q_valid && (state == SHIFT) &&
                         (bit_cnt == CNT_W'(WIDTH - 1));
    // The buffer can take a word if it is empty or is being read this cycle.
    buf_free           = !data_valid || data_ready;
`ifdef TFF_DEC_PARITY_EN
    par_ok             = (t_bit == ^shift_reg);
    par_bad            = q_valid && (state == PAR) && !par_ok;
    word_done          = q_valid && (state == PAR) && par_ok;
    word_val           = shift_reg;
`else
    word_done          = last_bit;
    word_val           = word_next;
`endif
  end

  // Frame FSM, bit collection and the one-word output buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      q_prev     <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
`ifdef TFF_DEC_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
`ifdef TFF_DEC_PARITY_EN
      parity_err <= par_bad;
`endif
      // Drain first; a word completing in the same cycle overrides this.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (word_done) begin
        if (buf_free) begin
          data_out   <= word_val;
          data_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (q_valid) begin
        q_prev <= q_in;
        case (state)
          IDLE: begin
            shift_reg <= word_next;
            bit_cnt   <= CNT_W'(1);
            state     <= SHIFT;
          end
          SHIFT: begin
            shift_reg <= word_next;
            if (last_bit) begin
              bit_cnt <= '0;
`ifdef TFF_DEC_PARITY_EN
              state   <= PAR;
`else
              state   <= IDLE;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          PAR: begin
            state <= IDLE;
          end
          default: begin
            state   <= IDLE;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifndef TFF_DEC_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/tff_stream_decoder.md
# tff_stream_decoder

Receive-side counterpart of the team's T flip-flop: it samples a line driven by a toggle (T) flip-flop and recovers the original T bit stream, T = Q XOR Q_prev. Recovered bits are assembled LSB-first into WIDTH-bit words and handed downstream over a valid/ready handshake with a one-word output buffer. Under a compile-time macro, each word also carries an even-parity check bit. It sits directly after the toggle-encoded link, or after the SR/JK/D-based T flip-flop under test, and lets a bench or datapath read back the stimulus that drove `t`.

## Interface
- WIDTH, 8, bits per recovered word (2..32)
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- q_in  input  1  sampled Q line of the remote T flip-flop
- q_valid  input  1  q_in is a new sample this cycle
- data_out  output  WIDTH  recovered word, bit 0 = first recovered bit
- data_valid  output  1  data_out holds an unread word
- data_ready  input  1  downstream accepts data_out this cycle
- overflow  output  1  sticky: a completed word was dropped because the buffer was full
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without the macro

## Operation
- Reference register `q_prev` resets to 0, matching the T flip-flop's reset state Q=0.
- Each accepted sample (q_valid=1): t_bit = q_in ^ q_prev, then q_prev <= q_in.
  - t_bit shifts into the shift register at position bit_cnt (LSB-first).
  - bit_cnt increments.
- No state changes when q_valid=0.
- FSM states:
  - IDLE: bit_cnt=0. The first sample goes to SHIFT. If WIDTH bits are complete in one sample (never, since WIDTH≥2), the FSM stays in IDLE.
  - SHIFT: collects bits.
    - On the sample that makes bit_cnt=WIDTH, the word is complete. bit_cnt returns to 0.
    - The next state is IDLE, or PAR with the macro.
  - PAR (macro only): the next sample is the parity bit.
    - If the parity bit ≠ XOR of the word, parity_err pulses and the word is discarded.
    - Otherwise the word is complete.
    - Next state is IDLE.
- Word completion:
  - The word loads data_out and data_valid goes 1 if the buffer is empty, or if it is being drained this cycle (data_valid & data_ready). Drain and load then happen in the same cycle with no bubble.
  - Otherwise the word is dropped, overflow goes to 1 and stays 1 until reset, and the buffered word is kept.
- Handshake:
  - data_out and data_valid hold stable while data_valid=1 and data_ready=0.
  - data_valid falls the cycle after data_valid & data_ready if no new word completes that cycle.
- data_ready while data_valid=0 is ignored.
- Reset mid-word clears the partial word, q_prev, bit_cnt and the FSM. There is no partial output.

## Timing
- Reset values: data_out=0, data_valid=0, overflow=0, parity_err=0. Also q_prev=0, bit_cnt=0, state=IDLE.
- Latency: data_valid rises on the clock edge that accepts the last bit (parity bit with the macro). It is visible the following cycle.
- Throughput: one bit per cycle. Back-to-back words with data_ready tied high never overflow.
- parity_err is high for exactly one cycle, on the edge that accepts the bad parity bit.
- An asynchronous assertion of rst forces all outputs to their reset values immediately, independent of clk.

## Configuration
- TFF_DEC_PARITY_EN defined:
  - Frames are WIDTH+1 bits; the PAR state exists.
  - The trailing recovered bit is an even-parity bit (XOR of data bits).
  - Mismatched words pulse parity_err and are discarded without touching data_out, data_valid or overflow.
- TFF_DEC_PARITY_EN undefined:
  - Frames are WIDTH bits; there is no PAR state.
  - parity_err is tied to 0.

## Test plan
- Decode 0xA5 (WIDTH=8, no parity, data_ready=1):
  - Stimulus: after reset, q_in = 1,1,0,0,0,1,1,0 on consecutive q_valid cycles.
  - Required: data_out=0xA5 and data_valid=1 for one cycle after the 8th sample.
- All-zero and all-one words:
  - Stimulus: q_in held 0 for 8 samples, then q_in = 1,0,1,0,1,0,1,0.
  - Required: 0x00, then 0xFF; overflow stays 0.
- Overflow:
  - Stimulus: data_ready=0; send 0xA5, then 0x00.
  - Required: data_out stays 0xA5 and overflow=1.
  - Then raise data_ready: data_valid drops the next cycle, and overflow remains 1.
- q_valid gaps:
  - Stimulus: the 0xA5 sequence with q_valid=0 idle cycles between samples, q_in toggling randomly during the gaps.
  - Required: result 0xA5.
- Reset mid-word:
  - Stimulus: after 4 samples of the 0xA5 sequence, pulse rst low for 1 cycle, then send the full 0x00 sequence.
  - Required: data_out=0x00; no word is emitted for the aborted frame.
- Parity (TFF_DEC_PARITY_EN only):
  - Good frame: 0xA5 followed by q_in=0 as the 9th sample gives data_out=0xA5.
  - Bad frame: 9th sample q_in=1 gives a parity_err pulse and data_valid stays 0.
